pipe_delay_line: RTL and testbench



---
 rtl/pipe_delay_line.sv | 113 +++++++++++
 tb/tb_pipe_delay_line.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_delay_line.sv
// pipe_delay_line: DEPTH-stage valid/ready register chain with collapsing bubbles and synchronous flush.
// Define PIPE_DELAY_OCC_EN to add an occupancy output counting the valid stages.
module pipe_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
`ifdef PIPE_DELAY_OCC_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
`endif
);

  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] v_d;
  logic [DEPTH-1:0] rdy;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  logic [DEPTH:0]   chain_v;
  logic [WIDTH-1:0] chain_d [DEPTH+1];
  logic             in_fire;

  // A stage can take new data unless it and every stage after it are full and the output is stalled.
  always_comb begin
    logic tail_full;
    tail_full = 1'b1;
    rdy = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      tail_full = tail_full & v_q[i];
      rdy[i] = !tail_full | out_ready;
    end
  end

  assign in_ready  = rdy[0] & !flush;
  assign in_fire   = in_valid & in_ready;
  assign out_valid = v_q[DEPTH-1];
  assign out_data  = d_q[DEPTH-1];

  always_comb begin
    chain_v    = {v_q, in_fire};
    chain_d[0] = in_data;
    for (int i = 0; i < DEPTH; i++) begin
      chain_d[i+1] = d_q[i];
    end
    v_d = v_q;
    d_d = d_q;
    if (flush) begin
      v_d = '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (rdy[i]) begin
          v_d[i] = chain_v[i];
          if (chain_v[i]) begin
            d_d[i] = chain_d[i];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      v_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        d_q[i] <= '0;
      end
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

`ifdef PIPE_DELAY_OCC_EN
  localparam int OccW = $clog2(DEPTH + 1);

  logic            out_fire;
  logic [OccW-1:0] occ_q;
  logic [OccW-1:0] occ_d;

  assign out_fire = out_valid & out_ready;

  // in_fire is already blocked during flush, so only the clear needs special handling.
  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else if (in_fire && !out_fire) begin
      occ_d = occ_q + OccW'(1);
    end else if (!in_fire && out_fire) begin
      occ_d = occ_q - OccW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;
`endif

endmodule

// File: tb/tb_pipe_delay_line.sv
// Directed table-driven bench for pipe_delay_line (WIDTH=8, DEPTH=4).
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_pipe_delay_line;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
`ifdef PIPE_DELAY_OCC_EN
  logic [$clog2(DEPTH+1)-1:0] occupancy;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst_n;
    logic       fl;
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    logic       chk;
    logic       e_ir;
    logic       e_ov;
    logic [7:0] e_od;
    int         e_occ;
  } vec_t;

  vec_t vecs[$];

  pipe_delay_line #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
`ifdef PIPE_DELAY_OCC_EN
    ,
    .occupancy (occupancy)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic addVector(input logic rst_n, input logic fl, input logic iv, input logic [7:0] id,
                           input logic ordy, input logic chk, input logic e_ir, input logic e_ov,
                           input logic [7:0] e_od, input int e_occ);
    vec_t v;
    v.rst_n = rst_n; v.fl = fl; v.iv = iv; v.id = id; v.ordy = ordy;
    v.chk = chk; v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_occ = e_occ;
    vecs.push_back(v);
  endtask

  task automatic checkOutput(input string tag, input logic e_ir, input logic e_ov,
                             input logic [7:0] e_od, input int e_occ);
    checks++;
    if (in_ready !== e_ir) begin
      errors++;
      $display("[TB] FAIL %s in_ready: got %b expected %b", tag, in_ready, e_ir);
    end
    checks++;
    if (out_valid !== e_ov) begin
      errors++;
      $display("[TB] FAIL %s out_valid: got %b expected %b", tag, out_valid, e_ov);
    end
    checks++;
    if (out_data !== e_od) begin
      errors++;
      $display("[TB] FAIL %s out_data: got %h expected %h", tag, out_data, e_od);
    end
`ifdef PIPE_DELAY_OCC_EN
    checks++;
    if (int'(occupancy) != e_occ) begin
      errors++;
      $display("[TB] FAIL %s occupancy: got %0d expected %0d", tag, occupancy, e_occ);
    end
`endif
  endtask

  // One cycle: drive inputs, check before the next rising edge, then step past it.
  task automatic applyStimulus(input string tag, input logic rst_n, input logic fl, input logic iv,
                               input logic [7:0] id, input logic ordy, input logic chk,
                               input logic e_ir, input logic e_ov, input logic [7:0] e_od,
                               input int e_occ);
    reset     = rst_n;
    flush     = fl;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    @(negedge clk);
    if (chk) checkOutput(tag, e_ir, e_ov, e_od, e_occ);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc;
    int outn;

    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    @(posedge clk);
    #1;

    // rst_n fl iv id ordy | chk ir ov od occ
    addVector(0, 0, 1, 8'h11, 0, 0, 1, 0, 8'h00, 0);
    addVector(0, 0, 1, 8'h22, 0, 1, 1, 0, 8'h00, 0);
    addVector(1, 0, 0, 8'h00, 0, 1, 1, 0, 8'h00, 0);
    addVector(1, 0, 1, 8'hA0, 0, 1, 1, 0, 8'h00, 0);
    addVector(1, 0, 1, 8'hA1, 0, 1, 1, 0, 8'h00, 1);
    addVector(1, 0, 1, 8'hA2, 0, 1, 1, 0, 8'h00, 2);
    addVector(1, 0, 1, 8'hA3, 0, 1, 1, 0, 8'h00, 3);
    addVector(1, 0, 1, 8'hA4, 0, 1, 0, 1, 8'hA0, 4);
    addVector(1, 0, 1, 8'hA5, 0, 1, 0, 1, 8'hA0, 4);
    addVector(1, 0, 1, 8'hA4, 1, 1, 1, 1, 8'hA0, 4);
    addVector(1, 0, 1, 8'hA5, 1, 1, 1, 1, 8'hA1, 4);
    addVector(1, 0, 0, 8'h00, 1, 1, 1, 1, 8'hA2, 4);
    addVector(1, 0, 0, 8'h00, 1, 1, 1, 1, 8'hA3, 3);
    addVector(1, 0, 0, 8'h00, 1, 1, 1, 1, 8'hA4, 2);
    addVector(1, 0, 0, 8'h00, 1, 1, 1, 1, 8'hA5, 1);
    addVector(1, 0, 0, 8'h00, 0, 1, 1, 0, 8'hA5, 0);
    addVector(1, 0, 1, 8'h55, 0, 1, 1, 0, 8'hA5, 0);
    addVector(1, 0, 0, 8'h00, 0, 1, 1, 0, 8'hA5, 1);
    addVector(1, 0, 0, 8'h00, 0, 1, 1, 0, 8'hA5, 1);
    addVector(1, 0, 0, 8'h00, 0, 1, 1, 0, 8'hA5, 1);
    addVector(1, 0, 1, 8'h66, 0, 1, 1, 1, 8'h55, 1);
    addVector(1, 0, 0, 8'h00, 0, 1, 1, 1, 8'h55, 2);
    addVector(1, 0, 0, 8'h00, 0, 1, 1, 1, 8'h55, 2);
    addVector(1, 0, 0, 8'h00, 0, 1, 1, 1, 8'h55, 2);
    addVector(1, 0, 0, 8'h00, 1, 1, 1, 1, 8'h55, 2);
    addVector(1, 0, 0, 8'h00, 1, 1, 1, 1, 8'h66, 1);
    addVector(1, 0, 0, 8'h00, 1, 1, 1, 0, 8'h66, 0);
    addVector(1, 0, 1, 8'hB1, 1, 1, 1, 0, 8'h66, 0);
    addVector(1, 0, 1, 8'hB2, 1, 1, 1, 0, 8'h66, 1);
    addVector(1, 0, 1, 8'hB3, 1, 1, 1, 0, 8'h66, 2);
    addVector(1, 1, 1, 8'hB4, 1, 1, 0, 0, 8'h66, 3);
    addVector(1, 0, 0, 8'h00, 1, 1, 1, 0, 8'h66, 0);
    addVector(1, 0, 0, 8'h00, 1, 1, 1, 0, 8'h66, 0);
    addVector(1, 0, 0, 8'h00, 1, 1, 1, 0, 8'h66, 0);
    addVector(1, 0, 1, 8'hC1, 1, 1, 1, 0, 8'h66, 0);
    addVector(1, 0, 0, 8'h00, 1, 1, 1, 0, 8'h66, 1);
    addVector(1, 0, 0, 8'h00, 1, 1, 1, 0, 8'h66, 1);
    addVector(1, 0, 0, 8'h00, 1, 1, 1, 0, 8'h66, 1);
    addVector(1, 0, 0, 8'h00, 1, 1, 1, 1, 8'hC1, 1);
    addVector(1, 0, 0, 8'h00, 1, 1, 1, 0, 8'hC1, 0);
    addVector(1, 0, 1, 8'hD1, 1, 1, 1, 0, 8'hC1, 0);
    addVector(0, 0, 0, 8'h00, 1, 1, 1, 0, 8'hC1, 1);
    addVector(1, 0, 0, 8'h00, 1, 1, 1, 0, 8'h00, 0);
    addVector(1, 0, 0, 8'h00, 1, 1, 1, 0, 8'h00, 0);
    addVector(1, 0, 0, 8'h00, 1, 1, 1, 0, 8'h00, 0);
    addVector(1, 0, 0, 8'h00, 1, 1, 1, 0, 8'h00, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i].rst_n, vecs[i].fl, vecs[i].iv, vecs[i].id,
                    vecs[i].ordy, vecs[i].chk, vecs[i].e_ir, vecs[i].e_ov, vecs[i].e_od,
                    vecs[i].e_occ);
    end

    // Back-to-back stream 0x01..0x10: item k is visible at the check of cycle k+4.
    for (int c = 0; c < 22; c++) begin
      acc  = (c < 16) ? c : 16;
      outn = (c > 4) ? ((c - 4 < 16) ? c - 4 : 16) : 0;
      applyStimulus($sformatf("stream%0d", c), 1, 0, (c < 16), 8'(c + 1), 1, 1, 1,
                    (c >= 4 && c < 20),
                    (c < 4) ? 8'h00 : ((c < 20) ? 8'(c - 3) : 8'h10),
                    acc - outn);
    end

    // Fill with a stalled output, then stream in and out together while full.
    for (int j = 0; j < 4; j++) begin
      applyStimulus($sformatf("fill%0d", j), 1, 0, 1, 8'(8'hC0 + j), 0, 1, 1, 0, 8'h10, j);
    end
    applyStimulus("full_stall", 1, 0, 1, 8'hC4, 0, 1, 0, 1, 8'hC0, 4);
    for (int j = 0; j < 10; j++) begin
      applyStimulus($sformatf("full_io%0d", j), 1, 0, 1, 8'(8'hC4 + j), 1, 1, 1, 1,
                    8'(8'hC0 + j), 4);
    end
    for (int j = 0; j < 4; j++) begin
      applyStimulus($sformatf("drain%0d", j), 1, 0, 0, 8'h00, 1, 1, 1, 1,
                    8'(8'hCA + j), 4 - j);
    end
    applyStimulus("empty_end", 1, 0, 0, 8'h00, 1, 1, 1, 0, 8'hCD, 0);

    $display("[TB] directed sequences complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
